spi_slave_shifter: RTL

SPI responder (slave) data path with control, the counterpart to the master-side shifter. It oversamples the external SCK/SS_n/MOSI pins in the system clock domain, shifts received bits into a receive register and drives transmit bits on MISO in all four CPOL/CPHA modes. It exposes an SPDR-style register interface, with SPIF/WCOL/OVR flags, to the local host or controller.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_slave_shifter_if.sv | 27 ++
 rtl/spi_sync2.sv | 24 ++
 rtl/spi_slave_shifter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI responder data path.
// Mode encoding is {cpol, cpha}.
package spi_pkg;

    localparam int SPI_DWIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } spi_state_e;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_slave_shifter_if.sv
// SPI pin bundle between an external master and the responder.
// The master drives sck/ss_n/mosi; the responder drives miso/miso_oe.
interface spi_slave_shifter_if;

    logic sck;
    logic ss_n;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (
        output sck,
        output ss_n,
        output mosi,
        input  miso,
        input  miso_oe
    );

    modport slave (
        input  sck,
        input  ss_n,
        input  mosi,
        output miso,
        output miso_oe
    );

endinterface

// File: rtl/spi_sync2.sv
// Two-flop synchronizer for one asynchronous pin.
// RST_VAL should match the pin's idle level.
module spi_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= {2{RST_VAL}};
        end else begin
            sr_q <= {sr_q[0], d_i};
        end
    end

    assign q_o = sr_q[1];

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI responder: oversampled pins, rx/tx shift registers and
// SPDR-style host register with SPIF/WCOL/OVR flags.
module spi_slave_shifter
    import spi_pkg::*;
#(
    parameter int DWIDTH = SPI_DWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    spi_slave_shifter_if.slave spi,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              SPDR_wr_en,
    input  logic [DWIDTH-1:0] SPDR_in,
    input  logic              flag_clr,
    output logic [DWIDTH-1:0] SPDR_out,
    output logic              spif,
    output logic              wcol,
    output logic              ovr,
    output logic              busy
);

    localparam int CW = $clog2(DWIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWIDTH - 1);

    logic sck_s;
    logic ss_s;
    logic mosi_s;
    logic sck_d_q;

    spi_sync2 #(.RST_VAL(1'b0)) u_sync_sck (
        .clk (clk),
        .rst (rst),
        .d_i (spi.sck),
        .q_o (sck_s)
    );

    spi_sync2 #(.RST_VAL(1'b1)) u_sync_ss (
        .clk (clk),
        .rst (rst),
        .d_i (spi.ss_n),
        .q_o (ss_s)
    );

    spi_sync2 #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk (clk),
        .rst (rst),
        .d_i (spi.mosi),
        .q_o (mosi_s)
    );

    spi_state_e        state_q, state_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DWIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [DWIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [DWIDTH-1:0] tx_buf_q, tx_buf_d;
    logic [DWIDTH-1:0] spdr_q, spdr_d;
    logic              spif_q, spif_d;
    logic              wcol_q, wcol_d;
    logic              ovr_q, ovr_d;

    logic              sck_edge;
    logic              lead_e;
    logic              trail_e;
    logic              sample_e;
    logic              shift_e;
    logic [DWIDTH-1:0] rx_next;

    assign sck_edge = sck_s ^ sck_d_q;
    assign lead_e   = sck_edge & (sck_s != cpol);
    assign trail_e  = sck_edge & (sck_s == cpol);
    assign rx_next  = {rx_sr_q[DWIDTH-2:0], mosi_s};

    always_comb begin
        sample_e = 1'b0;
        shift_e  = 1'b0;
        unique case ({cpol, cpha})
            MODE0, MODE2: begin
                sample_e = lead_e;
                shift_e  = trail_e;
            end
            MODE1, MODE3: begin
                sample_e = trail_e;
                shift_e  = lead_e;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_sr_d   = rx_sr_q;
        tx_sr_d   = tx_sr_q;
        tx_buf_d  = tx_buf_q;
        spdr_d    = spdr_q;
        spif_d    = spif_q & ~flag_clr;
        wcol_d    = wcol_q & ~flag_clr;
        ovr_d     = ovr_q & ~flag_clr;

        // tx_buf may only change between words
        if (SPDR_wr_en) begin
            if (bit_cnt_q == '0) begin
                tx_buf_d = SPDR_in;
            end else begin
                wcol_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (!ss_s) begin
                    state_d   = XFER;
                    tx_sr_d   = tx_buf_q;
                    bit_cnt_d = '0;
                end
            end
            XFER: begin
                if (ss_s) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    rx_sr_d   = '0;
                end else if (sample_e) begin
                    rx_sr_d = rx_next;
                    if (bit_cnt_q == CNT_LAST) begin
                        bit_cnt_d = '0;
                        spdr_d    = rx_next;
                        ovr_d     = ovr_d | spif_q;
                        spif_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (shift_e) begin
                    if (bit_cnt_q == '0) begin
                        tx_sr_d = tx_buf_q;
                    end else begin
                        tx_sr_d = {tx_sr_q[DWIDTH-2:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sck_d_q   <= 1'b0;
            bit_cnt_q <= '0;
            rx_sr_q   <= '0;
            tx_sr_q   <= '0;
            tx_buf_q  <= '0;
            spdr_q    <= '0;
            spif_q    <= 1'b0;
            wcol_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sck_d_q   <= sck_s;
            bit_cnt_q <= bit_cnt_d;
            rx_sr_q   <= rx_sr_d;
            tx_sr_q   <= tx_sr_d;
            tx_buf_q  <= tx_buf_d;
            spdr_q    <= spdr_d;
            spif_q    <= spif_d;
            wcol_q    <= wcol_d;
            ovr_q     <= ovr_d;
        end
    end

    assign busy        = (state_q == XFER);
    assign spi.miso    = busy & tx_sr_q[DWIDTH-1];
    assign spi.miso_oe = busy;
    assign SPDR_out    = spdr_q;
    assign spif        = spif_q;
    assign wcol        = wcol_q;
    assign ovr         = ovr_q;

endmodule
